// File: rtl/math_multiplier_shift_add_pkg.sv
// Shared definitions for the shift-add multiplier-accumulator.
//   state_e : FSM state encoding (Idle/Run/Done)
//   clog2   : ceiling log2, used to size the step counter
package math_multiplier_shift_add_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/math_multiplier_add_step.sv
// One conditional-add step of a shift-add multiplier.
//   acc_i   : running partial sum
//   mcand_i : multiplicand aligned to the current multiplier bit
//   bit_i   : current multiplier bit
//   sum_o   : acc_i + (bit_i ? mcand_i : 0), same width, no carry-out
module math_multiplier_add_step #(
  parameter int unsigned Width = 13
) (
  input  logic [Width-1:0] acc_i,
  input  logic [Width-1:0] mcand_i,
  input  logic             bit_i,
  output logic [Width-1:0] sum_o
);

  assign sum_o = acc_i + (bit_i ? mcand_i : '0);

endmodule

// File: rtl/math_multiplier_shift_add.sv
// Sequential radix-2 shift-add multiplier-accumulator: p = x*y + r.
// One multiplier bit per clock; result after exactly yWIDTH RUN edges.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (ready only when idle)
//   x, y, r              : multiplicand, multiplier, addend
//   out_valid / out_ready: result handshake, p held while stalled
//   p                    : x*y + r, wide enough to never overflow
module math_multiplier_shift_add
  import math_multiplier_shift_add_pkg::*;
#(
  parameter int unsigned xWIDTH = 8,
  parameter int unsigned yWIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [xWIDTH-1:0]        x,
  input  logic [yWIDTH-1:0]        y,
  input  logic [yWIDTH:0]          r,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [xWIDTH+yWIDTH:0]   p
);

  localparam int unsigned PW   = xWIDTH + yWIDTH + 1;
  localparam int unsigned CntW = clog2(yWIDTH) + 1;

  state_e            state_q, state_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     mcand_q, mcand_d;
  logic [yWIDTH-1:0] mplier_q, mplier_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [PW-1:0]     p_q, p_d;
  logic              out_valid_q, out_valid_d;
  logic [PW-1:0]     acc_sum;

  math_multiplier_add_step #(
    .Width (PW)
  ) u_add_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .bit_i   (mplier_q[0]),
    .sum_o   (acc_sum)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    count_d     = count_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;

    case (state_q)
      StIdle: begin
        if (in_valid) begin
          acc_d    = PW'(r);
          mcand_d  = PW'(x);
          mplier_d = y;
          count_d  = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CntW'(1);
        // Last multiplier bit: publish the sum including this step's add.
        if (count_q == CntW'(yWIDTH - 1)) begin
          state_d     = StDone;
          out_valid_d = 1'b1;
          p_d         = acc_sum;
        end
      end
      StDone: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      count_q     <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      count_q     <= count_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule

// File: tb/tb_math_multiplier_shift_add.sv
module tb_math_multiplier_shift_add;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  x = '0;
  logic [3:0]  y = '0;
  logic [4:0]  r = '0;
  logic        in_ready;
  logic        out_valid;
  logic [12:0] p;

  int n_tests = 0;
  int n_fail  = 0;

  math_multiplier_shift_add #(
    .xWIDTH (8),
    .yWIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .r         (r),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transaction: accept, wait for result, optional stall, handoff.
  // exp_p comes from the caller (constant or plain arithmetic).
  task automatic run_op(input logic [7:0] xi, input logic [3:0] yi, input logic [4:0] ri,
                        input int exp_p, input int hold, input bit junk, input string tag);
    int lat;
    check($sformatf("%s in_ready_idle", tag), 32'(in_ready), 32'd1);
    x = xi; y = yi; r = ri;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    step();
    if (junk) begin
      // Keep offering different operands; they must not be captured.
      x = ~xi; y = ~yi; r = ~ri;
    end else begin
      in_valid = 1'b0;
    end
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (junk) check($sformatf("%s in_ready_run", tag), 32'(in_ready), 32'd0);
      step();
      lat++;
    end
    check($sformatf("%s latency", tag), 32'(lat), 32'd4);
    check($sformatf("%s p", tag), 32'(p), 32'(exp_p));
    for (int i = 0; i < hold; i++) begin
      check($sformatf("%s in_ready_done", tag), 32'(in_ready), 32'd0);
      step();
      check($sformatf("%s stall_valid", tag), 32'(out_valid), 32'd1);
      check($sformatf("%s stall_p", tag), 32'(p), 32'(exp_p));
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check($sformatf("%s handoff_valid", tag), 32'(out_valid), 32'd0);
    check($sformatf("%s handoff_ready", tag), 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] xo, q, xr;
    logic [3:0] yo, rm, yr;
    logic [4:0] rr;

    #1;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset p", 32'(p), 32'd0);
    step();
    step();
    rst = 1'b0;

    run_op(8'h2A, 4'd5, 5'd3, 213, 0, 1'b0, "basic");
    run_op(8'hFF, 4'hF, 5'h1F, 3856, 0, 1'b0, "max");
    run_op(8'h99, 4'd0, 5'd7, 7, 0, 1'b0, "y_zero");
    run_op(8'h5A, 4'hB, 5'h11, 90 * 11 + 17, 3, 1'b0, "backpressure");
    run_op(8'h77, 4'd9, 5'd2, 119 * 9 + 2, 2, 1'b1, "ignore_busy");
    run_op(8'h10, 4'd2, 5'd1, 33, 0, 1'b1, "ignore_run");

    // Reset in the middle of RUN, between the 1st and 2nd RUN edges.
    x = 8'h2A; y = 4'd5; r = 5'd3;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    #2;
    rst = 1'b1;
    #1;
    check("midrun_rst out_valid", 32'(out_valid), 32'd0);
    check("midrun_rst p", 32'(p), 32'd0);
    check("midrun_rst in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("midrun_rst no_stale", 32'(out_valid), 32'd0);
      step();
    end
    run_op(8'd3, 4'd3, 5'd0, 9, 0, 1'b0, "after_rst");

    for (int i = 0; i < 50; i++) begin
      xr = 8'($urandom_range(0, 255));
      yr = 4'($urandom_range(0, 15));
      rr = 5'($urandom_range(0, 31));
      run_op(xr, yr, rr, int'(xr) * int'(yr) + int'(rr), int'($urandom_range(0, 2)),
             1'($urandom_range(0, 1)), "random");
    end

    // Divider round trip: q*y + rem must rebuild the dividend.
    for (int i = 0; i < 1000; i++) begin
      xo = 8'($urandom_range(0, 255));
      yo = 4'($urandom_range(1, 15));
      q  = 8'(int'(xo) / int'(yo));
      rm = 4'(int'(xo) % int'(yo));
      run_op(q, yo, {1'b0, rm}, int'(xo), 0, 1'b0, "roundtrip");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
